// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: shared types for the icache tag store (parity bit enabled by SNITCH_ICACHE_TAG_PARITY_EN)
package snitch_icache_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, READ} tag_store_state_e;
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
  localparam int unsigned TAG_PAR_BITS = 1;
`else
  localparam int unsigned TAG_PAR_BITS = 0;
`endif
  localparam int unsigned TAG_ENTRY_PAR_W = 20 + 2 + 1;
endpackage

// File: rtl/snitch_icache_tag_bank.sv
// snitch_icache_tag_bank: one set's tag SRAM with optional even parity (SNITCH_ICACHE_TAG_PARITY_EN)
module snitch_icache_tag_bank
  import snitch_icache_pkg::*;
#(
  parameter int unsigned LINE_COUNT = 128,
  parameter int unsigned EW = 22,
  parameter int unsigned SW = TAG_ENTRY_PAR_W,
  parameter type sram_cfg_t = logic,
  parameter int unsigned AW = $clog2(LINE_COUNT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  sram_cfg_t     sram_cfg_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [EW-1:0] wdata_i,
  output logic [EW-1:0] rdata_o,
  output logic          perr_o
);
  logic [SW-1:0] sram_wdata, sram_rdata;
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
  // stored parity xor recomputed parity reduces to the xor of the whole word
  assign sram_wdata = {^wdata_i, wdata_i};
  assign perr_o = ^sram_rdata;
`else
  assign sram_wdata = wdata_i;
  assign perr_o = 1'b0;
`endif
  assign rdata_o = sram_rdata[EW-1:0];
  tc_sram_impl #(
    .NumWords  (LINE_COUNT),
    .DataWidth (SW),
    .impl_in_t (sram_cfg_t)
  ) i_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .impl_i  (sram_cfg_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (sram_wdata),
    .rdata_o (sram_rdata)
  );
endmodule

// File: rtl/tc_sram_impl.sv
// tc_sram_impl: single-port SRAM model with one cycle read latency
module tc_sram_impl #(
  parameter int unsigned NumWords = 128,
  parameter int unsigned DataWidth = 22,
  parameter type impl_in_t = logic,
  parameter int unsigned AW = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  impl_in_t             impl_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);
  logic [DataWidth-1:0] mem [NumWords];
  logic unused_impl;
  assign unused_impl = ^impl_i;
  always_ff @(posedge clk_i) begin
    if (req_i && we_i) mem[addr_i] <= wdata_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_o <= '0;
    else if (req_i && !we_i) rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/snitch_icache_tag_store.sv
// snitch_icache_tag_store: per-set tag SRAMs with request port and invalidation sweep (parity: SNITCH_ICACHE_TAG_PARITY_EN)
module snitch_icache_tag_store
  import snitch_icache_pkg::*;
#(
  parameter int unsigned LINE_COUNT = 128,
  parameter int unsigned SET_COUNT = 2,
  parameter int unsigned TAG_WIDTH = 20,
  parameter type sram_cfg_t = logic,
  parameter int unsigned AW = $clog2(LINE_COUNT),
  parameter int unsigned EW = TAG_WIDTH + 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  sram_cfg_t                     sram_cfg_i,
  input  logic                          flush_i,
  output logic                          flush_busy_o,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_write_i,
  input  logic [AW-1:0]                 req_addr_i,
  input  logic [SET_COUNT-1:0]          req_set_mask_i,
  input  logic [SET_COUNT-1:0][EW-1:0]  req_wtag_i,
  output logic                          rsp_valid_o,
  output logic [SET_COUNT-1:0][EW-1:0]  rsp_rtag_o,
  output logic [SET_COUNT-1:0]          rsp_perr_o
);
  localparam logic [AW-1:0] LAST = AW'(LINE_COUNT - 1);
  tag_store_state_e state;
  logic [AW-1:0] cnt, addr;
  logic [SET_COUNT-1:0] mask_q, en, perr;
  logic [SET_COUNT-1:0][EW-1:0] wdata, rdata;
  logic busy, accept, we;
  assign busy = state == FLUSH;
  assign flush_busy_o = busy;
  assign req_ready_o = !busy && !flush_i;
  assign accept = req_valid_i && req_ready_o;
  assign en = busy ? '1 : (accept ? req_set_mask_i : '0);
  assign we = busy || req_write_i;
  assign addr = busy ? cnt : req_addr_i;
  assign wdata = busy ? '0 : req_wtag_i;
  assign rsp_valid_o = state == READ;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= FLUSH;
      cnt <= '0;
      mask_q <= '0;
    end else if (flush_i) begin
      state <= FLUSH;
      cnt <= '0;
    end else if (busy) begin
      state <= (cnt == LAST) ? IDLE : FLUSH;
      cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
    end else begin
      state <= (req_valid_i && !req_write_i) ? READ : IDLE;
      if (req_valid_i && !req_write_i) mask_q <= req_set_mask_i;
    end
  end
  for (genvar i = 0; i < SET_COUNT; i++) begin : g_set
    snitch_icache_tag_bank #(
      .LINE_COUNT (LINE_COUNT),
      .EW         (EW),
      .SW         (EW + TAG_PAR_BITS),
      .sram_cfg_t (sram_cfg_t)
    ) i_bank (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .sram_cfg_i (sram_cfg_i),
      .req_i      (en[i]),
      .we_i       (we),
      .addr_i     (addr),
      .wdata_i    (wdata[i]),
      .rdata_o    (rdata[i]),
      .perr_o     (perr[i])
    );
    // unread sets still hold stale SRAM output, so gate by the captured mask
    assign rsp_rtag_o[i] = (rsp_valid_o && mask_q[i]) ? rdata[i] : '0;
    assign rsp_perr_o[i] = rsp_valid_o && mask_q[i] && perr[i];
  end
endmodule

// File: tb/tb_snitch_icache_tag_store.sv
// tb_snitch_icache_tag_store: random and directed checks against a line-array reference model
module tb_snitch_icache_tag_store;
  localparam int LC = 128;
  localparam int SC = 2;
  localparam int TW = 20;
  localparam int EW = TW + 2;
  localparam int AW = $clog2(LC);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic valid = 1'b0;
  logic write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [SC-1:0] mask = '0;
  logic [SC-1:0][EW-1:0] wtag = '0;
  logic busy, ready, rsp_valid;
  logic [SC-1:0][EW-1:0] rtag;
  logic [SC-1:0] perr;
  logic [EW-1:0] model [SC][LC];
  logic bad [SC][LC];
  int sweep_left = LC;
  logic exp_valid = 1'b0;
  logic [SC-1:0][EW-1:0] exp_rtag = '0;
  logic [SC-1:0] exp_perr = '0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snitch_icache_tag_store #(
    .LINE_COUNT (LC),
    .SET_COUNT  (SC),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sram_cfg_i     (1'b0),
    .flush_i        (flush),
    .flush_busy_o   (busy),
    .req_valid_i    (valid),
    .req_ready_o    (ready),
    .req_write_i    (write),
    .req_addr_i     (addr),
    .req_set_mask_i (mask),
    .req_wtag_i     (wtag),
    .rsp_valid_o    (rsp_valid),
    .rsp_rtag_o     (rtag),
    .rsp_perr_o     (perr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < SC; s++)
      for (int a = 0; a < LC; a++) begin
        model[s][a] = '0;
        bad[s][a] = 1'b0;
      end
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [SC-1:0] m,
                       input logic [SC-1:0][EW-1:0] d, input logic f);
    valid = v; write = w; addr = a; mask = m; wtag = d; flush = f;
  endtask

  task automatic step();
    logic acc;
    @(negedge clk);
    chk("busy", 64'(busy), 64'(sweep_left > 0));
    chk("ready", 64'(ready), 64'(rst_n && sweep_left == 0 && !flush));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    chk("rsp_rtag", 64'(rtag), 64'(exp_rtag));
    chk("rsp_perr", 64'(perr), 64'(exp_perr));
    @(posedge clk);
    if (!rst_n) begin
      sweep_left = LC; exp_valid = 1'b0; exp_rtag = '0; exp_perr = '0;
      clear_model();
    end else begin
      acc = valid && !flush && sweep_left == 0;
      exp_valid = acc && !write;
      exp_rtag = '0; exp_perr = '0;
      for (int s = 0; s < SC; s++) begin
        if (exp_valid && mask[s]) begin
          exp_rtag[s] = model[s][addr];
          exp_perr[s] = bad[s][addr];
        end
        if (acc && write && mask[s]) begin
          model[s][addr] = wtag[s];
          bad[s][addr] = 1'b0;
        end
      end
      if (flush) begin
        sweep_left = LC;
        clear_model();
      end else if (sweep_left > 0) sweep_left--;
    end
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, '0, '0, '0, 0);
    repeat (n) step();
  endtask

  initial begin
    logic [63:0] r;
    clear_model();
    repeat (3) step();
    rst_n = 1'b1;
    idle(LC);
    drive(1, 0, AW'(LC - 1), 2'b11, '0, 0); step();
    idle(1);
    drive(1, 1, AW'(5), 2'b11, {22'h112345, 22'h3ABCDE}, 0); step();
    drive(1, 0, AW'(5), 2'b11, '0, 0); step();
    drive(1, 0, AW'(5), 2'b01, '0, 0); step();
    drive(1, 1, AW'(6), 2'b00, {22'h3FFFFF, 22'h3FFFFF}, 0); step();
    drive(1, 0, AW'(6), 2'b00, '0, 0); step();
    drive(1, 0, AW'(6), 2'b11, '0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, AW'(i), 2'b11, {22'(i * 7 + 1), 22'(i * 13 + 2)}, 0); step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, AW'(i), 2'b11, '0, 0); step();
    end
    idle(2);
    drive(1, 1, AW'(7), 2'b11, {22'h2AAAAA, 22'h155555}, 0); step();
    drive(1, 1, AW'(8), 2'b11, {22'h000111, 22'h000222}, 1); step();
    idle(60);
    drive(0, 0, '0, '0, '0, 1); step();
    idle(LC);
    drive(1, 0, AW'(7), 2'b11, '0, 0); step();
    drive(1, 1, AW'(3), 2'b10, {22'h0ABCDE, 22'h0}, 0); step();
    drive(1, 0, AW'(3), 2'b11, '0, 1); step();
    idle(40);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rtag", 64'(rtag), 64'd0);
    step();
    rst_n = 1'b1;
    idle(LC);
    drive(1, 0, AW'(3), 2'b11, '0, 0); step();
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
    drive(1, 1, AW'(9), 2'b11, {22'h12345, 22'h23456}, 0); step();
    idle(1);
    dut.g_set[1].i_bank.i_sram.mem[9][0] = ~dut.g_set[1].i_bank.i_sram.mem[9][0];
    model[1][9][0] = ~model[1][9][0];
    bad[1][9] = 1'b1;
    drive(1, 0, AW'(9), 2'b11, '0, 0); step();
    idle(1);
`endif
    for (int i = 0; i < 2500; i++) begin
      r = {$urandom(), $urandom()};
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
            SC'($urandom_range(0, 3)), r[SC*EW-1:0], $urandom_range(0, 299) == 0);
      step();
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
